// File: rtl/clink_uart_pkg.sv
// Shared types and constants for the CameraLink serial receiver.
package clink_uart_pkg;

    localparam int unsigned OVERSAMPLE        = 16;
    localparam int unsigned DEFAULT_CLK_FREQ  = 100_000_000;
    localparam int unsigned DEFAULT_BAUD_RATE = 9600;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Clocks per oversample tick, rounded to nearest, never below 1.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        int unsigned d;
        d = (clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/clink_uart_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO for the serial receiver.
module clink_uart_rx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [7:0]                 data_i,
    input  logic                       pop_i,
    output logic [7:0]                 data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       drop_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [7:0]    mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem[rd_ptr_q];
    assign count_o = count_q;

    // Storage write; contents need no reset since reads are gated by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/clink_uart_rx.sv
// 8N1 serial receiver with 16x oversampling, error flags and a FWFT FIFO.
module clink_uart_rx
    import clink_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_serial,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_error,
    output logic                          overrun,
    input  logic                          clear_errors
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [1:0]    sync_q;
    logic          rx_prev_q;
    logic          rxs;
    rx_state_e     state_q;
    logic [DW-1:0] div_q;
    logic [3:0]    tick_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          frame_err_q;
    logic          overrun_q;

    logic          tick;
    logic          fall;
    logic          stop_sample;
    logic          push_byte;
    logic          frame_evt;
    logic          fifo_drop;

    assign rxs         = sync_q[1];
    assign fall        = rx_prev_q && !rxs;
    assign tick        = (div_q == DW'(DIV - 1));
    assign stop_sample = (state_q == ST_STOP) && tick && (tick_q == 4'd15);
    assign push_byte   = stop_sample && rxs;
    assign frame_evt   = stop_sample && !rxs;

    // Two-flop synchronizer plus previous-value flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx_serial};
            rx_prev_q <= rxs;
        end
    end

    // Receive FSM with oversample divider, tick and bit counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            // Divider is held at zero in IDLE so it restarts on the start edge.
            if (state_q == ST_IDLE || tick) div_q <= '0;
            else                            div_q <= div_q + DW'(1);

            case (state_q)
                ST_IDLE: begin
                    tick_q <= '0;
                    bit_q  <= '0;
                    if (fall) state_q <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        if (tick_q == 4'd7) begin
                            tick_q  <= '0;
                            state_q <= rxs ? ST_IDLE : ST_DATA;
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (tick_q == 4'd15) begin
                            tick_q  <= '0;
                            shift_q <= {rxs, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'd7) state_q <= ST_STOP;
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (tick_q == 4'd15) begin
                            tick_q  <= '0;
                            state_q <= rxs ? ST_IDLE : ST_BREAK;
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rxs) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_evt || (frame_err_q && !clear_errors);
            overrun_q   <= fifo_drop || (overrun_q && !clear_errors);
        end
    end

    assign frame_error = frame_err_q;
    assign overrun     = overrun_q;

    clink_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_byte),
        .data_i  (shift_q),
        .pop_i   (rx_ready),
        .data_o  (rx_data),
        .valid_o (rx_valid),
        .count_o (fifo_count),
        .drop_o  (fifo_drop)
    );

endmodule

// File: tb/tb_clink_uart_rx.sv
// Scoreboard bench for clink_uart_rx, run at a fast baud rate to keep frames short.
module tb_clink_uart_rx;
    import clink_uart_pkg::*;

    localparam int unsigned CLK_FREQ = 100_000_000;
    localparam int unsigned BAUD     = 1_562_500;
    localparam int unsigned FDEPTH   = 16;
    localparam int          BIT_CYC  = 64;   // 100 MHz / 1.5625 Mbaud
    localparam int          CW       = $clog2(FDEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_serial;
    logic          rx_ready;
    logic          clear_errors;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [CW-1:0] fifo_count;
    logic          frame_error;
    logic          overrun;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [7:0]    exp_q[$];

    always #5 clk = ~clk;

    clink_uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .FIFO_DEPTH (FDEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_serial    (rx_serial),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .fifo_count   (fifo_count),
        .frame_error  (frame_error),
        .overrun      (overrun),
        .clear_errors (clear_errors)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int stop_len, input logic stop_lvl,
                             input bit expect_it);
        if (expect_it) exp_q.push_back(b);
        rx_serial = 1'b0;
        wait_cycles(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            wait_cycles(BIT_CYC);
        end
        rx_serial = stop_lvl;
        wait_cycles(BIT_CYC * stop_len);
        rx_serial = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit expect_it);
        send_bits(b, 1, 1'b1, expect_it);
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_none"}, 32'(rx_valid), 32'd0);
        end else begin
            check_eq({tag, "_valid"}, 32'(rx_valid), 32'd1);
            check_eq(tag, 32'(rx_data), 32'(exp_q.pop_front()));
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    // Waits for the push strobe and checks first-word fall-through latency.
    task automatic watch_fwft();
        bit seen = 1'b0;
        for (int i = 0; i < 12 * BIT_CYC; i++) begin
            @(negedge clk);
            if (dut.push_byte) begin
                seen = 1'b1;
                check_eq("fwft_before", 32'(rx_valid), 32'd0);
                @(negedge clk);
                check_eq("fwft_after", 32'(rx_valid), 32'd1);
                break;
            end
        end
        check_eq("fwft_push_seen", 32'(seen), 32'd1);
    endtask

    // Pulses clear_errors on the exact cycle the stop bit is sampled low.
    task automatic clear_on_frame_evt();
        bit seen = 1'b0;
        for (int i = 0; i < 12 * BIT_CYC; i++) begin
            @(negedge clk);
            if (dut.frame_evt) begin
                seen = 1'b1;
                clear_errors = 1'b1;
                @(negedge clk);
                clear_errors = 1'b0;
                break;
            end
        end
        check_eq("clr_evt_seen", 32'(seen), 32'd1);
    endtask

    // Pops exactly on the cycle a byte is pushed into a full FIFO.
    task automatic pop_on_push();
        bit seen = 1'b0;
        for (int i = 0; i < 12 * BIT_CYC; i++) begin
            @(negedge clk);
            if (dut.push_byte) begin
                seen = 1'b1;
                check_eq("full_pop_head", 32'(rx_data), 32'(exp_q.pop_front()));
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                break;
            end
        end
        check_eq("full_push_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        rx_serial    = 1'b1;
        rx_ready     = 1'b0;
        clear_errors = 1'b0;
        wait_cycles(5);

        // Reset state
        check_eq("rst_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_data",  32'(rx_data), 32'd0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_ferr",  32'(frame_error), 32'd0);
        check_eq("rst_ovr",   32'(overrun), 32'd0);
        check_eq("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset = 1'b0;
        wait_cycles(BIT_CYC);

        // Single byte 0x48 with FWFT latency
        fork
            send_byte(8'h48, 1'b1);
            watch_fwft();
        join
        check_eq("b48_count", 32'(fifo_count), 32'd1);
        check_eq("b48_ferr",  32'(frame_error), 32'd0);
        check_eq("b48_ovr",   32'(overrun), 32'd0);
        pop_check("b48_data");
        check_eq("b48_empty", 32'(rx_valid), 32'd0);

        // Short glitch on idle line
        rx_serial = 1'b0;
        wait_cycles(10);
        rx_serial = 1'b1;
        wait_cycles(BIT_CYC);
        check_eq("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
        check_eq("glitch_count", 32'(fifo_count), 32'd0);
        check_eq("glitch_ferr",  32'(frame_error), 32'd0);
        check_eq("glitch_ovr",   32'(overrun), 32'd0);

        // Framing error (clear pulsed coincident with the event), then 0xA5
        fork
            send_bits(8'h55, 2, 1'b0, 1'b0);
            clear_on_frame_evt();
        join
        check_eq("ferr_set", 32'(frame_error), 32'd1);
        wait_cycles(BIT_CYC);
        send_byte(8'hA5, 1'b1);
        check_eq("ferr_count", 32'(fifo_count), 32'd1);
        pop_check("ferr_a5");
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
        check_eq("ferr_cleared", 32'(frame_error), 32'd0);

        // Overrun: 17 bytes with no consumer
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        check_eq("ovr_full_count", 32'(fifo_count), 32'd16);
        check_eq("ovr_not_yet",    32'(overrun), 32'd0);
        send_byte(8'h10, 1'b0);
        check_eq("ovr_count", 32'(fifo_count), 32'd16);
        check_eq("ovr_set",   32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) pop_check("ovr_pop");
        check_eq("ovr_drained", 32'(fifo_count), 32'd0);
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
        check_eq("ovr_cleared", 32'(overrun), 32'd0);

        // Reset during bit 4 of 0x3C, then 0xC3
        begin
            logic [7:0] b;
            b = 8'h3C;
            rx_serial = 1'b0;
            wait_cycles(BIT_CYC);
            for (int i = 0; i < 4; i++) begin
                rx_serial = b[i];
                wait_cycles(BIT_CYC);
            end
            rx_serial = b[4];
            wait_cycles(BIT_CYC / 2);
            reset = 1'b1;
            wait_cycles(4);
            rx_serial = 1'b1;
            reset = 1'b0;
        end
        check_eq("mrst_count", 32'(fifo_count), 32'd0);
        check_eq("mrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        wait_cycles(2 * BIT_CYC);
        check_eq("mrst_idle_count", 32'(fifo_count), 32'd0);
        send_byte(8'hC3, 1'b1);
        check_eq("mrst_c3_count", 32'(fifo_count), 32'd1);
        pop_check("mrst_c3");

        // Back-to-back frames with zero idle time
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        check_eq("b2b_count", 32'(fifo_count), 32'd2);
        check_eq("b2b_ovr",   32'(overrun), 32'd0);
        pop_check("b2b_00");
        pop_check("b2b_ff");

        // Push into a full FIFO with a simultaneous pop
        for (int i = 0; i < 16; i++) send_byte(8'(32'h20 + i), 1'b1);
        check_eq("fullrw_pre", 32'(fifo_count), 32'd16);
        fork
            send_byte(8'h30, 1'b1);
            pop_on_push();
        join
        check_eq("fullrw_count", 32'(fifo_count), 32'd16);
        check_eq("fullrw_ovr",   32'(overrun), 32'd0);
        for (int i = 0; i < 16; i++) pop_check("fullrw_pop");
        check_eq("fullrw_drained", 32'(fifo_count), 32'd0);
        check_eq("fullrw_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
